// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_capture_pkg : shared types and constants for PWM input capture   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } cap_state_e;

  localparam int PWM_CAP_SYNC_MIN = 2;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_capture_edge : synchroniser, inversion and rise/fall detection   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pwm_capture_edge
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  input  logic inv_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int STAGES = (SYNC_STAGES < PWM_CAP_SYNC_MIN) ? PWM_CAP_SYNC_MIN : SYNC_STAGES;

  logic [STAGES-1:0] sync;
  logic              cur;
  logic              prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync <= '0;
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pwm_i};
      cur  <= sync[STAGES-1] ^ inv_i;
      prev <= cur;
    end
  end

  assign rise_o = cur & ~prev;
  assign fall_o = ~cur & prev;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_capture : PWM period / high-time capture with valid/ready output |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int PSCR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  inv_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic                  pwm_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  per_o,
  output logic [CNT_WIDTH-1:0]  high_o,
  output logic                  drop_o,
  output logic                  tmo_o
);

  logic rise;
  logic fall;

  pwm_capture_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pwm_i  (pwm_i),
    .inv_i  (inv_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic [PSCR_WIDTH-1:0] div_cnt;
  logic [PSCR_WIDTH-1:0] pscr_eff;
  logic                  tick;

  assign pscr_eff = (pscr_i == '0) ? PSCR_WIDTH'(1) : pscr_i;
  // >= rather than == so a live decrease of pscr_i cannot strand the divider
  assign tick     = rise | (div_cnt >= (pscr_eff - PSCR_WIDTH'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + PSCR_WIDTH'(1);
    end
  end

  cap_state_e           state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] hi_cap, hi_cap_n;
  logic                 emit;
  logic                 tmo_evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= CAP_IDLE;
      cnt    <= '0;
      hi_cap <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_cap <= hi_cap_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_cap_n = hi_cap;
    emit     = 1'b0;
    tmo_evt  = 1'b0;
    case (state)
      CAP_IDLE: begin
        cnt_n = '0;
        if (en_i && rise) begin
          state_n = CAP_HIGH;
          cnt_n   = CNT_WIDTH'(1);
        end
      end
      CAP_HIGH, CAP_LOW: begin
        if (tick) begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
        if (!en_i) begin
          state_n = CAP_IDLE;
          cnt_n   = '0;
        end else if (tick && (&cnt)) begin
          tmo_evt = 1'b1;
          state_n = CAP_IDLE;
          cnt_n   = '0;
        end else if ((state == CAP_HIGH) && fall) begin
          hi_cap_n = cnt;
          state_n  = CAP_LOW;
        end else if ((state == CAP_LOW) && rise) begin
          emit    = 1'b1;
          cnt_n   = CNT_WIDTH'(1);
          state_n = CAP_HIGH;
        end
      end
      default: begin
        state_n = CAP_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      per_o   <= '0;
      high_o  <= '0;
      drop_o  <= 1'b0;
      tmo_o   <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      tmo_o  <= tmo_evt;
      if (emit && (!valid_o || ready_i)) begin
        valid_o <= 1'b1;
        per_o   <= cnt;
        high_o  <= hi_cap;
      end else if (emit) begin
        drop_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_capture : directed self-checking bench for pwm_capture        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int PW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst, en, inv, ready, pwm;
  logic [PW-1:0] pscr;
  logic          valid_o, drop_o, tmo_o;
  logic [CW-1:0] per_o, high_o;

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_WIDTH   (CW),
    .PSCR_WIDTH  (PW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .inv_i   (inv),
    .pscr_i  (pscr),
    .pwm_i   (pwm),
    .valid_o (valid_o),
    .ready_i (ready),
    .per_o   (per_o),
    .high_o  (high_o),
    .drop_o  (drop_o),
    .tmo_o   (tmo_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_drop = 0, n_tmo = 0, n_res = 0;

  // Model: measurement expressed as timestamps and ceil arithmetic.
  logic [SS-1:0] pq;
  logic          lev_now, lev_prev;
  int            mstate;   // 0 idle, 1 measuring high, 2 measuring low
  int            ts, hi, cyc_n;
  logic          m_valid, m_drop, m_tmo;
  logic [CW-1:0] m_per, m_high;

  task automatic model_step();
    int p, d, cnt;
    logic rise, fall, emit, tick;
    logic [CW-1:0] e_per, e_high;
    cyc_n++;
    if (rst) begin
      pq = '0; lev_now = 1'b0; lev_prev = 1'b0;
      mstate = 0; m_valid = 1'b0; m_drop = 1'b0; m_tmo = 1'b0;
      m_per = '0; m_high = '0;
    end else begin
      p    = (pscr == 0) ? 1 : int'(pscr);
      rise = lev_now & ~lev_prev;
      fall = ~lev_now & lev_prev;
      emit = 1'b0; m_drop = 1'b0; m_tmo = 1'b0;
      e_per = '0; e_high = '0;
      if (mstate != 0) begin
        d    = cyc_n - ts;
        tick = rise || ((d % p) == 0);
        cnt  = 1 + (d - 1) / p;
        if (!en) mstate = 0;
        else if (tick && cnt == (1 << CW) - 1) begin m_tmo = 1'b1; mstate = 0; end
        else if (mstate == 1 && fall) begin hi = cnt; mstate = 2; end
        else if (mstate == 2 && rise) begin
          emit = 1'b1; e_per = CW'(cnt); e_high = CW'(hi); ts = cyc_n; mstate = 1;
        end
      end else if (rise && en) begin
        mstate = 1; ts = cyc_n;
      end
      if (emit && (!m_valid || ready)) begin
        m_valid = 1'b1; m_per = e_per; m_high = e_high;
      end else if (emit) m_drop = 1'b1;
      else if (m_valid && ready) m_valid = 1'b0;
      lev_prev = lev_now;
      lev_now  = pq[SS-1] ^ inv;
      pq       = {pq[SS-2:0], pwm};
    end
  endtask

  initial begin
    cyc_n = 0; ts = 0; hi = 0; mstate = 0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      vectors++;
      if (valid_o !== m_valid || per_o !== m_per || high_o !== m_high ||
          drop_o !== m_drop || tmo_o !== m_tmo) begin
        miscompares++;
        $display("FAIL cycle %0d: dut v/per/high/drop/tmo=%b/%0d/%0d/%b/%b required %b/%0d/%0d/%b/%b",
                 cyc_n, valid_o, per_o, high_o, drop_o, tmo_o,
                 m_valid, m_per, m_high, m_drop, m_tmo);
      end
      if (drop_o === 1'b1) n_drop++;
      if (tmo_o === 1'b1) n_tmo++;
      if (valid_o === 1'b1 && ready === 1'b1) n_res++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wave(input int per, input int hi_t, input int reps);
    for (int i = 0; i < reps; i++) begin
      pwm = 1'b1; cyc(hi_t);
      pwm = 1'b0; cyc(per - hi_t);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; inv = 1'b0; ready = 1'b1; pwm = 1'b0; pscr = 16'd1;
    cyc(3);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_per", int'(per_o), 0);
    chk("reset_high", int'(high_o), 0);
    rst = 1'b0;
    cyc(5);

    // Basic measurement, pscr=1
    n_res = 0; en = 1'b1;
    wave(100, 30, 4);
    chk("t1_per", int'(per_o), 100);
    chk("t1_high", int'(high_o), 30);
    chk("t1_model_per", int'(m_per), 100);
    chk("t1_results", n_res, 3);
    en = 1'b0; cyc(3);

    // Prescaled, then inverted
    pscr = 16'd4; en = 1'b1;
    wave(100, 30, 3);
    chk("t2_per", int'(per_o), 25);
    chk("t2_high", int'(high_o), 8);
    chk("t2_model_high", int'(m_high), 8);
    en = 1'b0; inv = 1'b1; cyc(5);
    en = 1'b1;
    wave(100, 30, 3);
    chk("t2_inv_per", int'(per_o), 25);
    chk("t2_inv_high", int'(high_o), 18);
    en = 1'b0; inv = 1'b0; cyc(5);

    // pscr=0 behaves as 1
    pscr = 16'd0; en = 1'b1;
    wave(60, 20, 3);
    chk("pscr0_per", int'(per_o), 60);
    chk("pscr0_high", int'(high_o), 20);
    en = 1'b0; cyc(3); pscr = 16'd1;

    // Back-pressure: first result held, later ones dropped
    ready = 1'b0; n_drop = 0; en = 1'b1;
    pwm = 1'b1; cyc(30); pwm = 1'b0; cyc(70);
    wave(80, 20, 3);
    chk("t3_valid_held", int'(valid_o), 1);
    chk("t3_per_held", int'(per_o), 100);
    chk("t3_high_held", int'(high_o), 30);
    chk("t3_drops", n_drop, 2);
    ready = 1'b1; cyc(1);
    chk("t3_valid_cleared", int'(valid_o), 0);
    en = 1'b0; cyc(3);

    // Constant-high input: single timeout
    n_tmo = 0; en = 1'b1; pwm = 1'b1;
    cyc(300);
    chk("t4_tmo_count", n_tmo, 1);
    chk("t4_valid", int'(valid_o), 0);
    pwm = 1'b0; cyc(5);
    en = 1'b0; cyc(2);

    // Enable dropped mid-LOW
    ready = 1'b1; en = 1'b1; n_res = 0;
    pwm = 1'b1; cyc(30); pwm = 1'b0; cyc(40);
    en = 1'b0; cyc(5); en = 1'b1; cyc(25);
    wave(100, 30, 1);
    chk("t5_no_result", n_res, 0);
    wave(100, 30, 1);
    chk("t5_one_result", n_res, 1);
    chk("t5_per", int'(per_o), 100);

    // Reset while a result is pending and FSM is measuring high
    ready = 1'b0;
    pwm = 1'b1; cyc(10);
    chk("t6_pre_valid", int'(valid_o), 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("t6_valid", int'(valid_o), 0);
    chk("t6_per", int'(per_o), 0);
    chk("t6_drop", int'(drop_o), 0);
    chk("t6_tmo", int'(tmo_o), 0);
    cyc(20); pwm = 1'b0; cyc(70);
    ready = 1'b1;
    wave(100, 30, 3);
    chk("t6_resume_per", int'(per_o), 100);
    chk("t6_resume_high", int'(high_o), 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Single-channel PWM input capture core, the receive-side counterpart of the PWM generator. Synchronises an external PWM waveform and measures period and high time in prescaled ticks. Delivers each completed measurement over a valid/ready handshake. Sits behind an APB4 register wrapper, or directly in front of a consumer such as a motor-feedback or duty-monitor block.

## Interface
Parameters:
- CNT_WIDTH, 16, width of the period/high counters and results
- PSCR_WIDTH, 16, width of the prescaler value
- SYNC_STAGES, 2, synchroniser depth on pwm_i (minimum 2)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- en_i  in  1  capture enable
- inv_i  in  1  invert pwm_i after synchronisation
- pscr_i  in  PSCR_WIDTH  tick divider; 0 treated as 1
- pwm_i  in  1  asynchronous PWM input
- valid_o  out  1  measurement available
- ready_i  in  1  consumer accepts measurement
- per_o  out  CNT_WIDTH  period in ticks
- high_o  out  CNT_WIDTH  high time in ticks
- drop_o  out  1  one-cycle pulse: completed measurement discarded
- tmo_o  out  1  one-cycle pulse: counter saturated, measurement aborted

## Operation
- Input path: SYNC_STAGES flops, then XOR with inv_i, then one history flop. rise = cur & ~prev; fall = ~cur & prev.
- Tick generator: divider counter restarts on every rise. Tick is asserted in the rise cycle and every max(pscr_i,1)-th cycle after it. pscr_i is sampled live, so a change applies from the next divider wrap.
- FSM:
  - IDLE: cnt = 0. On rise with en_i, go to HIGH with cnt = 1. The first edge never produces a result.
  - HIGH: cnt += 1 per tick. On fall, latch hi_cap = cnt and go to LOW.
  - LOW: cnt += 1 per tick. On rise, emit (per = cnt, high = hi_cap), set cnt = 1, go to HIGH.
- Timeout: in HIGH or LOW, when a tick occurs with cnt all-ones, pulse tmo_o, go to IDLE and discard the measurement. A constant 0% or 100% input therefore ends in IDLE with tmo_o pulses only.
- en_i low: FSM goes to IDLE the next cycle and the in-progress measurement is discarded. A pending result is kept until accepted.
- Output register:
  - On emit with valid_o low, or with valid_o & ready_i in the same cycle: load per_o/high_o and set valid_o.
  - On emit with valid_o high and ready_i low: keep the old result and pulse drop_o.
  - valid_o & ready_i with no emit: clear valid_o.
- per_o and high_o hold their value while valid_o is high.
- Reset values: FSM IDLE; cnt, divider and sync flops 0; valid_o, drop_o, tmo_o 0; per_o, high_o 0.

## Timing
- pwm_i edge to rise/fall detection: SYNC_STAGES+1 clocks.
- Emit happens in the detection cycle of the closing rise; valid_o and data are registered and appear one clock later. Total pwm_i rise to valid_o: SYNC_STAGES+2 clocks.
- With pscr_i = 1, an input of period N clocks and high time H clocks gives per_o = N and high_o = H. In general per_o = ceil(N/p) and high_o = ceil(H/p), with p = max(pscr_i,1).
- Minimum measurable pulse width: 1 clock after synchronisation. Shorter pulses may be missed, with no error reported.
- Throughput: one result per input period. ready_i may be held low indefinitely without stalling capture (results drop).
- rst_i asserted mid-measurement: all state returns to reset values on the next edge; no result or pulse is produced.

## Structure
- Package pwm_capture_pkg holds:
  - typedef enum logic [1:0] {CAP_IDLE, CAP_HIGH, CAP_LOW} cap_state_e
  - PWM_CAP_SYNC_MIN = 2
- Sub-module pwm_capture_edge: synchroniser, inversion and rise/fall detection. It carries its own synchronous active-high reset.
- Top level holds the tick divider, FSM, counters and output handshake register.

## Test plan
- pscr_i=1, inv_i=0, pwm_i period 100 clocks, high 30: second rise yields valid_o with per_o=100 and high_o=30. Repeats every 100 clocks with ready_i=1.
- pscr_i=4, period 100, high 30: per_o=25, high_o=8 (ceil). Same input with inv_i=1 gives per_o=25, high_o=18.
- ready_i held low across three periods: first result is held unchanged; drop_o pulses once per later period. Raising ready_i clears valid_o next cycle.
- CNT_WIDTH=8, pscr_i=1, pwm_i held high after one rise: tmo_o pulses exactly once 255 ticks later, FSM returns to IDLE, and valid_o stays 0.
- en_i dropped mid-LOW, then restored: no result for the interrupted period; the first result after re-enable comes only after two rises.
- rst_i pulsed one cycle while valid_o=1 and FSM=HIGH: next cycle valid_o=0, per_o=0, and no drop_o/tmo_o. Capture resumes on the next rise.
